// File: rtl/instr_mem_sync.sv
// Registered-read instruction memory for the fetch path: valid/ready fetch port
// with optional wait states and fault reporting, plus a byte-enabled load port.
module instr_mem_sync #(
   parameter int unsigned DEPTH_WORDS = 32768,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_instr,
   output logic        rsp_fault,
   input  logic        rsp_ready,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   input  logic [3:0]  ld_be
);

   localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [33:0] SPAN      = 34'(DEPTH_WORDS) << 2;
   localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state, state_next;
   logic [3:0]  wait_cnt, wait_cnt_next;
   logic [31:0] addr_q;
   logic        accept;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0]      rd_addr, rd_off, ld_off;
   logic [IDX_W-1:0] rd_idx, ld_idx;
   logic             rd_fault, ld_hit, rsp_load;

   assign accept = req_valid && req_ready;

   // The response samples the live request address when there are no wait
   // states, otherwise the address captured at acceptance.
   assign rd_addr  = (state == S_WAIT) ? addr_q : req_addr;
   assign rd_off   = rd_addr - BASE_ADDR;
   assign rd_idx   = rd_off[IDX_W+1:2];
   assign rd_fault = (rd_addr[1:0] != 2'b00) || (rd_addr < BASE_ADDR) ||
                     ({2'b00, rd_off} >= SPAN);

   assign ld_off = ld_addr - BASE_ADDR;
   assign ld_idx = ld_off[IDX_W+1:2];
   assign ld_hit = (ld_addr >= BASE_ADDR) && ({2'b00, ld_off} < SPAN);

   assign rsp_load = !reset && ((accept && NO_WAIT) || (state == S_WAIT && wait_cnt == 4'd0));

   // State register and wait counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q <= req_addr;
      end
   end

   // Next-state logic; an acceptance from RESP reuses the same entry path as from IDLE
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_next    = NO_WAIT ? S_RESP : S_WAIT;
               wait_cnt_next = WAIT_LOAD;
            end
         end
         S_WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_next = S_RESP;
            end else begin
               wait_cnt_next = wait_cnt - 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               if (accept) begin
                  state_next    = NO_WAIT ? S_RESP : S_WAIT;
                  wait_cnt_next = WAIT_LOAD;
               end else begin
                  state_next = S_IDLE;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the registered state
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = (state == S_RESP);
      if (!reset) begin
         req_ready = (state == S_IDLE) || (state == S_RESP && rsp_ready);
      end
   end

   // Response payload only changes on entry to RESP; memory is skipped on a fault
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_instr <= 32'h0;
         rsp_fault <= 1'b0;
      end else if (rsp_load) begin
         rsp_fault <= rd_fault;
         rsp_instr <= rd_fault ? 32'h0 : mem[rd_idx];
      end
   end

   // Load port; the response read above sees the pre-write contents
   always_ff @(posedge clk) begin
      if (!reset && ld_en && ld_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (ld_be[b]) begin
               mem[ld_idx][8*b +: 8] <= ld_data[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: three instances (no wait / 3 waits at a high base /
// 5 waits) driven by directed sequences and checked against a transaction model.
module tb_instr_mem_sync;

   localparam int unsigned MDEPTH = 64;
   localparam logic [31:0] BASE0  = 32'h0000_0000;
   localparam logic [31:0] BASE1  = 32'h8000_0000;
   localparam logic [31:0] BASE2  = 32'h0000_1000;
   localparam int          W0     = 0;
   localparam int          W1     = 3;
   localparam int          W2     = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset     [3];
   logic        req_valid [3];
   logic [31:0] req_addr  [3];
   logic        rsp_ready [3];
   logic        ld_en     [3];
   logic [31:0] ld_addr   [3];
   logic [31:0] ld_data   [3];
   logic [3:0]  ld_be     [3];
   wire         req_ready [3];
   wire         rsp_valid [3];
   wire  [31:0] rsp_instr [3];
   wire         rsp_fault [3];

   instr_mem_sync #(.DEPTH_WORDS(MDEPTH), .BASE_ADDR(BASE0), .WAIT_CYCLES(W0)) dut0 (
      .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
      .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_instr(rsp_instr[0]),
      .rsp_fault(rsp_fault[0]), .rsp_ready(rsp_ready[0]), .ld_en(ld_en[0]),
      .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .ld_be(ld_be[0]));

   instr_mem_sync #(.DEPTH_WORDS(MDEPTH), .BASE_ADDR(BASE1), .WAIT_CYCLES(W1)) dut1 (
      .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
      .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_instr(rsp_instr[1]),
      .rsp_fault(rsp_fault[1]), .rsp_ready(rsp_ready[1]), .ld_en(ld_en[1]),
      .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .ld_be(ld_be[1]));

   instr_mem_sync #(.DEPTH_WORDS(MDEPTH), .BASE_ADDR(BASE2), .WAIT_CYCLES(W2)) dut2 (
      .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_addr(req_addr[2]),
      .req_ready(req_ready[2]), .rsp_valid(rsp_valid[2]), .rsp_instr(rsp_instr[2]),
      .rsp_fault(rsp_fault[2]), .rsp_ready(rsp_ready[2]), .ld_en(ld_en[2]),
      .ld_addr(ld_addr[2]), .ld_data(ld_data[2]), .ld_be(ld_be[2]));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Transaction-level model: a response is due W edges after the accepting edge
   logic [31:0] mmem    [3][MDEPTH];
   bit          m_valid [3];
   logic [31:0] m_instr [3];
   bit          m_fault [3];
   bit          m_pend  [3];
   longint      m_due   [3];
   logic [31:0] m_addr  [3];
   bit          m_rdy   [3];
   longint      cyc = 0;

   function automatic logic [31:0] baseOf(input int i);
      case (i)
         0:       return BASE0;
         1:       return BASE1;
         default: return BASE2;
      endcase
   endfunction

   function automatic int waitOf(input int i);
      case (i)
         0:       return W0;
         1:       return W1;
         default: return W2;
      endcase
   endfunction

   function automatic bit modelReady(input int i);
      return !reset[i] && !m_pend[i] && (!m_valid[i] || rsp_ready[i]);
   endfunction

   task automatic modelRespond(input int i, input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(baseOf(i));
      m_valid[i] = 1'b1;
      if (a[1:0] != 2'b00 || off < 0 || off >= longint'(MDEPTH) * 4) begin
         m_fault[i] = 1'b1;
         m_instr[i] = 32'h0;
      end else begin
         m_fault[i] = 1'b0;
         m_instr[i] = mmem[i][int'(off / 4)];
      end
   endtask

   task automatic modelLoad(input int i);
      longint off;
      off = longint'({ld_addr[i][31:2], 2'b00}) - longint'(baseOf(i));
      if (off >= 0 && off < longint'(MDEPTH) * 4) begin
         for (int b = 0; b < 4; b++) begin
            if (ld_be[i][b]) mmem[i][int'(off / 4)][8*b +: 8] = ld_data[i][8*b +: 8];
         end
      end
   endtask

   task automatic modelStep();
      cyc++;
      for (int i = 0; i < 3; i++) m_rdy[i] = modelReady(i);
      for (int i = 0; i < 3; i++) begin
         if (reset[i]) begin
            m_valid[i] = 1'b0;
            m_instr[i] = 32'h0;
            m_fault[i] = 1'b0;
            m_pend[i]  = 1'b0;
         end else begin
            if (m_valid[i] && rsp_ready[i]) m_valid[i] = 1'b0;
            if (m_pend[i] && cyc == m_due[i]) begin
               modelRespond(i, m_addr[i]);
               m_pend[i] = 1'b0;
            end
            if (req_valid[i] && m_rdy[i]) begin
               if (waitOf(i) == 0) begin
                  modelRespond(i, req_addr[i]);
               end else begin
                  m_pend[i] = 1'b1;
                  m_due[i]  = cyc + longint'(waitOf(i));
                  m_addr[i] = req_addr[i];
               end
            end
            if (ld_en[i]) modelLoad(i);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         for (int w = 0; w < int'(MDEPTH); w++) mmem[i][w] = 32'h0;
      end
      forever begin
         @(posedge clk);
         modelStep();
      end
   end

   // Compare every DUT output against the model once per cycle
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("i%0d_req_ready", i), 32'(req_ready[i]), 32'(modelReady(i)));
            checkOutput($sformatf("i%0d_rsp_valid", i), 32'(rsp_valid[i]), 32'(m_valid[i]));
            checkOutput($sformatf("i%0d_rsp_instr", i), rsp_instr[i], m_instr[i]);
            checkOutput($sformatf("i%0d_rsp_fault", i), 32'(rsp_fault[i]), 32'(m_fault[i]));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic loadWord(input int i, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
      ld_en[i]   = 1'b1;
      ld_addr[i] = addr;
      ld_data[i] = data;
      ld_be[i]   = be;
      step();
      ld_en[i]   = 1'b0;
   endtask

   // Present a fetch and hold it until the accepting edge has passed
   task automatic applyStimulus(input int i, input logic [31:0] addr);
      int guard = 0;
      req_valid[i] = 1'b1;
      req_addr[i]  = addr;
      while (!req_ready[i] && guard < 50) begin
         step();
         guard++;
      end
      checkOutput($sformatf("i%0d_accept", i), 32'(req_ready[i]), 32'd1);
      step();
      req_valid[i] = 1'b0;
   endtask

   task automatic waitRsp(input int i, input int expLat, input string name);
      int n = 0;
      while (!rsp_valid[i] && n < 40) begin
         step();
         n++;
      end
      checkOutput({name, "_latency"}, 32'(n), 32'(expLat));
   endtask

   logic [31:0] got[$];
   logic [31:0] words [3] = '{32'h1111_0000, 32'h2222_1111, 32'h3333_2222};

   task automatic tickCapture();
      if (rsp_valid[0] && rsp_ready[0]) got.push_back(rsp_instr[0]);
      step();
   endtask

   task automatic fetchToggling(input logic [31:0] addr);
      int guard = 0;
      req_valid[0] = 1'b1;
      req_addr[0]  = addr;
      rsp_ready[0] = ~rsp_ready[0];
      #1;
      while (!req_ready[0] && guard < 20) begin
         tickCapture();
         guard++;
         rsp_ready[0] = ~rsp_ready[0];
         #1;
      end
      checkOutput("bp_accept", 32'(req_ready[0]), 32'd1);
      tickCapture();
      req_valid[0] = 1'b0;
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 3; i++) begin
         reset[i]     = 1'b1;
         req_valid[i] = 1'b0;
         req_addr[i]  = 32'h0;
         rsp_ready[i] = 1'b1;
         ld_en[i]     = 1'b0;
         ld_addr[i]   = 32'h0;
         ld_data[i]   = 32'h0;
         ld_be[i]     = 4'h0;
      end
      repeat (3) step();
      checkOutput("reset_req_ready", 32'(req_ready[0]), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid[1]), 32'd0);
      checkOutput("reset_rsp_instr", rsp_instr[2], 32'h0);
      for (int i = 0; i < 3; i++) reset[i] = 1'b0;
      step();

      // Load and fetch with no wait states
      loadWord(0, BASE0 + 32'd8, 32'h0050_0093, 4'hF);
      checkOutput("model_word2", mmem[0][2], 32'h0050_0093);
      applyStimulus(0, BASE0 + 32'd8);
      waitRsp(0, 0, "lf");
      checkOutput("lf_instr", rsp_instr[0], 32'h0050_0093);
      checkOutput("lf_fault", 32'(rsp_fault[0]), 32'd0);
      step();

      // Three wait states on an unloaded word
      applyStimulus(1, BASE1 + 32'h20);
      checkOutput("ws_ready_low", 32'(req_ready[1]), 32'd0);
      waitRsp(1, 3, "ws");
      checkOutput("ws_instr", rsp_instr[1], 32'h0);
      step();

      // Backpressure with rsp_ready toggling, then back-to-back with no bubbles
      for (int k = 0; k < 3; k++) loadWord(0, BASE0 + 32'(4 * k), words[k], 4'hF);
      got.delete();
      rsp_ready[0] = 1'b0;
      for (int k = 0; k < 3; k++) fetchToggling(BASE0 + 32'(4 * k));
      guard = 0;
      while (got.size() < 3 && guard < 40) begin
         rsp_ready[0] = ~rsp_ready[0];
         tickCapture();
         guard++;
      end
      checkOutput("bp_count", 32'(got.size()), 32'd3);
      for (int k = 0; k < 3 && k < got.size(); k++) begin
         checkOutput($sformatf("bp_order%0d", k), got[k], words[k]);
      end
      rsp_ready[0] = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         req_valid[0] = 1'b1;
         req_addr[0]  = BASE0 + 32'(4 * k);
         step();
         checkOutput($sformatf("bb_valid%0d", k), 32'(rsp_valid[0]), 32'd1);
         checkOutput($sformatf("bb_instr%0d", k), rsp_instr[0], words[k]);
      end
      req_valid[0] = 1'b0;
      step();

      // Faults: misaligned, past end, below base
      applyStimulus(0, BASE0 + 32'd2);
      waitRsp(0, 0, "mis");
      checkOutput("mis_fault", 32'(rsp_fault[0]), 32'd1);
      checkOutput("mis_instr", rsp_instr[0], 32'h0);
      step();
      applyStimulus(0, BASE0 + MDEPTH * 4);
      waitRsp(0, 0, "end");
      checkOutput("end_fault", 32'(rsp_fault[0]), 32'd1);
      checkOutput("end_instr", rsp_instr[0], 32'h0);
      step();
      applyStimulus(1, BASE1 - 32'd4);
      waitRsp(1, 3, "below");
      checkOutput("below_fault", 32'(rsp_fault[1]), 32'd1);
      checkOutput("below_instr", rsp_instr[1], 32'h0);
      step();
      applyStimulus(0, BASE0 + 32'd8);
      waitRsp(0, 0, "unch");
      checkOutput("unch_instr", rsp_instr[0], 32'h3333_2222);
      step();
      loadWord(0, BASE0 + MDEPTH * 4, 32'hDEAD_BEEF, 4'hF);
      applyStimulus(0, BASE0);
      waitRsp(0, 0, "oor_load");
      checkOutput("oor_load_instr", rsp_instr[0], 32'h1111_0000);
      step();

      // Partial write, then a write colliding with the response sample
      loadWord(0, BASE0 + 32'h10, 32'hAABB_CCDD, 4'hF);
      loadWord(0, BASE0 + 32'h10, 32'h0000_1100, 4'b0010);
      checkOutput("model_partial", mmem[0][4], 32'hAABB_11DD);
      applyStimulus(0, BASE0 + 32'h10);
      waitRsp(0, 0, "partial");
      checkOutput("partial_instr", rsp_instr[0], 32'hAABB_11DD);
      req_valid[0] = 1'b1;
      req_addr[0]  = BASE0 + 32'h10;
      ld_en[0]     = 1'b1;
      ld_addr[0]   = BASE0 + 32'h10;
      ld_data[0]   = 32'h1234_5678;
      ld_be[0]     = 4'hF;
      step();
      ld_en[0] = 1'b0;
      checkOutput("coll_old", rsp_instr[0], 32'hAABB_11DD);
      step();
      req_valid[0] = 1'b0;
      checkOutput("coll_new", rsp_instr[0], 32'h1234_5678);
      step();

      // Reset in the middle of a five-cycle wait
      loadWord(2, BASE2 + 32'd4, 32'hCAFE_F00D, 4'hF);
      applyStimulus(2, BASE2 + 32'd4);
      step();
      step();
      reset[2]   = 1'b1;
      ld_en[2]   = 1'b1;
      ld_addr[2] = BASE2 + 32'd12;
      ld_data[2] = 32'h55AA_55AA;
      ld_be[2]   = 4'hF;
      step();
      ld_en[2] = 1'b0;
      step();
      checkOutput("rst_ready_low", 32'(req_ready[2]), 32'd0);
      reset[2] = 1'b0;
      step();
      checkOutput("rst_idle_ready", 32'(req_ready[2]), 32'd1);
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("rst_no_rsp%0d", k), 32'(rsp_valid[2]), 32'd0);
         step();
      end
      applyStimulus(2, BASE2 + 32'd4);
      waitRsp(2, 5, "post_rst");
      checkOutput("post_rst_instr", rsp_instr[2], 32'hCAFE_F00D);
      step();
      applyStimulus(2, BASE2 + 32'd12);
      waitRsp(2, 5, "rst_load");
      checkOutput("rst_load_instr", rsp_instr[2], 32'h0);
      step();
      step();

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
